// File: rtl/dmac_slave.sv
// dmac_slave: register-mapped DMA controller slave.
// Holds the descriptor registers (SRC/DST/SIZE), a descriptor FIFO that the
// DMA master pops with rd_en, start/clear handshake pulses and status flags.
// Ports:
//   clk, reset_n           - clock, asynchronous active-low reset
//   S_sel/S_wr/S_address   - bus select, write strobe, register offset
//   S_din/S_dout           - bus write data, combinational read data
//   rd_en, opdone          - master pop request, transfer-complete input
//   opstart, opdone_clear  - registered one-cycle pulses to the master
//   opmode                 - address mode, straight from the OPMODE register
//   source_addr/dest_addr/data_size - last popped descriptor
//   data_count             - FIFO occupancy
//   intr                   - opdone gated by INT_EN
module dmac_slave #(
    parameter int unsigned FIFO_DEPTH = 8,  // power of 2, >= 2
    parameter int unsigned CNT_W      = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             S_sel,
    input  logic             S_wr,
    input  logic [7:0]       S_address,
    input  logic [31:0]      S_din,
    output logic [31:0]      S_dout,
    input  logic             rd_en,
    input  logic             opdone,
    output logic             opstart,
    output logic             opdone_clear,
    output logic [2:0]       opmode,
    output logic [7:0]       source_addr,
    output logic [7:0]       dest_addr,
    output logic [7:0]       data_size,
    output logic [CNT_W-1:0] data_count,
    output logic             intr
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

    localparam logic [7:0] AddrStart  = 8'h00;
    localparam logic [7:0] AddrIntr   = 8'h01;
    localparam logic [7:0] AddrIntEn  = 8'h02;
    localparam logic [7:0] AddrSrc    = 8'h03;
    localparam logic [7:0] AddrDst    = 8'h04;
    localparam logic [7:0] AddrSize   = 8'h05;
    localparam logic [7:0] AddrPush   = 8'h06;
    localparam logic [7:0] AddrCount  = 8'h07;
    localparam logic [7:0] AddrOpmode = 8'h08;
    localparam logic [7:0] AddrClear  = 8'h09;
    localparam logic [7:0] AddrStatus = 8'h0A;

    logic             int_en_q;
    logic [7:0]       src_q, dst_q, size_q;
    logic [2:0]       opmode_q;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             opstart_q, opdone_clear_q;
    logic [PtrW-1:0]  head_q, tail_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       src_out_q, dst_out_q, size_out_q;
    logic [23:0]      mem_q [FIFO_DEPTH];

    logic wr_en, wr_start, wr_push, wr_clear, wr_status;
    logic start_ok, pop_valid, full, push_ok;
    logic unused_din;

    assign unused_din = ^S_din[31:8];

    assign wr_en     = S_sel & S_wr;
    assign wr_start  = wr_en & (S_address == AddrStart) & S_din[0];
    assign wr_push   = wr_en & (S_address == AddrPush) & S_din[0];
    assign wr_clear  = wr_en & (S_address == AddrClear) & S_din[0];
    assign wr_status = wr_en & (S_address == AddrStatus);

    assign start_ok  = wr_start & ~busy_q & ~opdone;
    assign pop_valid = rd_en & (count_q != '0);
    assign full      = (count_q >= CNT_W'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot the push lands in.
    assign push_ok   = wr_push & (~full | pop_valid);

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop_valid})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // Setting a sticky flag takes priority over a same-cycle W1C.
        ovf_d  = (ovf_q & ~(wr_status & S_din[1])) | (wr_push & ~push_ok);
        udf_d  = (udf_q & ~(wr_status & S_din[2])) | (rd_en & (count_q == '0));
        busy_d = opdone ? 1'b0 : (start_ok ? 1'b1 : busy_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            int_en_q       <= 1'b0;
            src_q          <= '0;
            dst_q          <= '0;
            size_q         <= '0;
            opmode_q       <= '0;
            busy_q         <= 1'b0;
            ovf_q          <= 1'b0;
            udf_q          <= 1'b0;
            opstart_q      <= 1'b0;
            opdone_clear_q <= 1'b0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            src_out_q      <= '0;
            dst_out_q      <= '0;
            size_out_q     <= '0;
        end else begin
            busy_q         <= busy_d;
            ovf_q          <= ovf_d;
            udf_q          <= udf_d;
            count_q        <= count_d;
            opstart_q      <= start_ok;
            opdone_clear_q <= wr_clear;
            if (wr_en) begin
                case (S_address)
                    AddrIntEn:  int_en_q <= S_din[0];
                    AddrSrc:    src_q    <= S_din[7:0];
                    AddrDst:    dst_q    <= S_din[7:0];
                    AddrSize:   size_q   <= S_din[7:0];
                    AddrOpmode: if (!busy_q) opmode_q <= S_din[2:0];
                    default: ;
                endcase
            end
            if (push_ok) begin
                tail_q <= tail_q + PtrW'(1);
            end
            if (pop_valid) begin
                {src_out_q, dst_out_q, size_out_q} <= mem_q[head_q];
                head_q <= head_q + PtrW'(1);
            end
        end
    end

    // Descriptor storage is not reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[tail_q] <= {src_q, dst_q, size_q};
        end
    end

    always_comb begin
        S_dout = 32'h0;
        if (S_sel && !S_wr) begin
            case (S_address)
                AddrIntr:   S_dout[0]         = opdone;
                AddrIntEn:  S_dout[0]         = int_en_q;
                AddrSrc:    S_dout[7:0]       = src_q;
                AddrDst:    S_dout[7:0]       = dst_q;
                AddrSize:   S_dout[7:0]       = size_q;
                AddrCount:  S_dout[CNT_W-1:0] = count_q;
                AddrOpmode: S_dout[2:0]       = opmode_q;
                AddrStatus: S_dout[2:0]       = {udf_q, ovf_q, busy_q};
                default:    S_dout            = 32'h0;
            endcase
        end
    end

    assign opstart      = opstart_q;
    assign opdone_clear = opdone_clear_q;
    assign opmode       = opmode_q;
    assign source_addr  = src_out_q;
    assign dest_addr    = dst_out_q;
    assign data_size    = size_out_q;
    assign data_count   = count_q;
    assign intr         = opdone & int_en_q;
endmodule
